// File: rtl/z_core_pkg.sv
// Shared definitions for the z_core load/store unit: funct3 size codes,
// FSM state encodings, response codes and a funct3 legality helper.
package z_core_pkg;

  // RISC-V funct3 size/sign codes; bit 2 selects zero extension on loads.
  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3Dbl   = 3'b011;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;
  localparam logic [2:0] F3WordU = 3'b110;

  // LSU FSM state encodings.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBeat0 = 2'd1;
  localparam logic [1:0] StBeat1 = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  // Completion status carried into the response.
  typedef enum logic [1:0] {
    RespOk,
    RespBusErr,
    RespMisaligned,
    RespUnsupported
  } lsu_resp_e;

  // True when funct3 names an access the LSU implements; wide = 64-bit bus.
  function automatic logic f3_supported(input logic wen, input logic [2:0] funct3,
                                        input logic wide);
    if (wen) begin
      return (funct3 inside {F3Byte, F3Half, F3Word}) || (wide && funct3 == F3Dbl);
    end
    return (funct3 inside {F3Byte, F3Half, F3Word, F3ByteU, F3HalfU}) ||
           (wide && (funct3 inside {F3Dbl, F3WordU}));
  endfunction

endpackage

// File: rtl/z_core_lsu_if.sv
// Bundle of the core request/response and memory bus signals of the LSU.
// slave: the LSU's view. master: the core + memory side driving it.
interface z_core_lsu_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  resp_misaligned;
  logic                  mem_req;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [STRB_WIDTH-1:0] mem_wstrb;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;
  logic                  mem_err;

  modport slave (
    input  req_valid, req_wen, req_funct3, req_addr, req_wdata,
    input  mem_rdata, mem_ready, mem_err,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_misaligned,
    output mem_req, mem_wen, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output req_valid, req_wen, req_funct3, req_addr, req_wdata,
    output mem_rdata, mem_ready, mem_err,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_misaligned,
    input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/z_core_lsu_align.sv
// Combinational lane alignment for the LSU: store data/strobe placement over a
// two-beat window, misalignment detection, and load byte extraction/extension.
module z_core_lsu_align
  import z_core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  // request side (store placement, misalignment)
  input  logic [2:0]                   req_funct3_i,
  input  logic [$clog2(STRB_WIDTH)-1:0] req_offset_i,
  input  logic [DATA_WIDTH-1:0]        req_wdata_i,
  output logic [DATA_WIDTH-1:0]        wdata_lo_o,
  output logic [DATA_WIDTH-1:0]        wdata_hi_o,
  output logic [STRB_WIDTH-1:0]        wstrb_lo_o,
  output logic [STRB_WIDTH-1:0]        wstrb_hi_o,
  output logic                         misaligned_o,
  // load side (uses the captured request attributes)
  input  logic [2:0]                   ld_funct3_i,
  input  logic [$clog2(STRB_WIDTH)-1:0] ld_offset_i,
  input  logic [DATA_WIDTH-1:0]        ld_rdata_lo_i,
  input  logic [DATA_WIDTH-1:0]        ld_rdata_hi_i,
  output logic [DATA_WIDTH-1:0]        ld_rdata_o
);

  logic [3:0]              req_nbytes;
  logic [DATA_WIDTH-1:0]   wdata_masked;
  logic [2*DATA_WIDTH-1:0] wdata_wide;
  logic [2*STRB_WIDTH-1:0] strb_wide;

  // Store path: keep only the access bytes, then place them across two beats.
  always_comb begin
    req_nbytes   = 4'd1 << req_funct3_i[1:0];
    wdata_masked = '0;
    strb_wide    = '0;
    for (int i = 0; i < int'(STRB_WIDTH); i++) begin
      if (i < int'(req_nbytes)) wdata_masked[8*i +: 8] = req_wdata_i[8*i +: 8];
    end
    for (int i = 0; i < int'(2 * STRB_WIDTH); i++) begin
      strb_wide[i] = (i >= int'(req_offset_i)) &&
                     (i < int'(req_offset_i) + int'(req_nbytes));
    end
    wdata_wide   = {{DATA_WIDTH{1'b0}}, wdata_masked} << {req_offset_i, 3'b000};
    misaligned_o = (int'(req_offset_i) + int'(req_nbytes)) > int'(STRB_WIDTH);
  end

  assign wdata_lo_o = wdata_wide[DATA_WIDTH-1:0];
  assign wdata_hi_o = wdata_wide[2*DATA_WIDTH-1:DATA_WIDTH];
  assign wstrb_lo_o = strb_wide[STRB_WIDTH-1:0];
  assign wstrb_hi_o = strb_wide[2*STRB_WIDTH-1:STRB_WIDTH];

  logic [3:0]              ld_nbytes;
  logic [2*DATA_WIDTH-1:0] rdata_shift;
  logic [DATA_WIDTH-1:0]   rdata_raw;
  logic                    msb;
  logic                    fill;

  // Load path: merge both beats, shift the access down to byte 0, then extend.
  always_comb begin
    ld_nbytes   = 4'd1 << ld_funct3_i[1:0];
    rdata_shift = {ld_rdata_hi_i, ld_rdata_lo_i} >> {ld_offset_i, 3'b000};
    rdata_raw   = rdata_shift[DATA_WIDTH-1:0];
    case (ld_funct3_i[1:0])
      2'b00:   msb = rdata_raw[7];
      2'b01:   msb = rdata_raw[15];
      2'b10:   msb = rdata_raw[31];
      default: msb = rdata_raw[DATA_WIDTH-1];
    endcase
    fill       = msb & ~ld_funct3_i[2];
    ld_rdata_o = '0;
    for (int i = 0; i < int'(STRB_WIDTH); i++) begin
      ld_rdata_o[8*i +: 8] = (i < int'(ld_nbytes)) ? rdata_raw[8*i +: 8] : {8{fill}};
    end
  end

endmodule

// File: rtl/z_core_lsu.sv
// RISC-V load/store unit: accepts one core request at a time, issues one bus
// beat (or two for a split misaligned access) and returns a one-cycle response.
// Optional feature macro: Z_CORE_LSU_MISALIGN_SPLIT_EN splits misaligned
// accesses into two aligned beats instead of rejecting them.
module z_core_lsu
  import z_core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input logic           clk,
  input logic           reset,
  z_core_lsu_if.slave   bus
);

  localparam int unsigned OffW = $clog2(STRB_WIDTH);
`ifdef Z_CORE_LSU_MISALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  logic [1:0]            state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_wen_q, mem_wen_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_WIDTH-1:0] mem_wstrb_q, mem_wstrb_d;
  lsu_resp_e             resp_code_q, resp_code_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [OffW-1:0]       offset_q, offset_d;
  logic                  wen_q, wen_d;
  logic                  split_q, split_d;
  logic [DATA_WIDTH-1:0] wdata_hi_q, wdata_hi_d;
  logic [STRB_WIDTH-1:0] wstrb_hi_q, wstrb_hi_d;
  logic [DATA_WIDTH-1:0] rdata_lo_q, rdata_lo_d;

  logic [OffW-1:0]       req_offset;
  logic [DATA_WIDTH-1:0] wdata_lo, wdata_hi, ld_rdata, ld_rdata_lo;
  logic [STRB_WIDTH-1:0] wstrb_lo, wstrb_hi;
  logic                  misaligned;
  logic                  supported;

  assign req_offset  = bus.req_addr[OffW-1:0];
  assign supported   = f3_supported(bus.req_wen, bus.req_funct3, DATA_WIDTH == 64);
  // In BEAT1 the first beat's word sits in rdata_lo_q; otherwise it is on the bus.
  assign ld_rdata_lo = (state_q == StBeat1) ? rdata_lo_q : bus.mem_rdata;

  z_core_lsu_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) u_align (
    .req_funct3_i  (bus.req_funct3),
    .req_offset_i  (req_offset),
    .req_wdata_i   (bus.req_wdata),
    .wdata_lo_o    (wdata_lo),
    .wdata_hi_o    (wdata_hi),
    .wstrb_lo_o    (wstrb_lo),
    .wstrb_hi_o    (wstrb_hi),
    .misaligned_o  (misaligned),
    .ld_funct3_i   (funct3_q),
    .ld_offset_i   (offset_q),
    .ld_rdata_lo_i (ld_rdata_lo),
    .ld_rdata_hi_i (bus.mem_rdata),
    .ld_rdata_o    (ld_rdata)
  );

  // Next-state logic: request decode, beat sequencing and response capture.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = 1'b0;
    mem_wen_d    = mem_wen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    resp_code_d  = resp_code_q;
    resp_rdata_d = resp_rdata_q;
    funct3_d     = funct3_q;
    offset_d     = offset_q;
    wen_d        = wen_q;
    split_d      = split_q;
    wdata_hi_d   = wdata_hi_q;
    wstrb_hi_d   = wstrb_hi_q;
    rdata_lo_d   = rdata_lo_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          funct3_d = bus.req_funct3;
          offset_d = req_offset;
          wen_d    = bus.req_wen;
          split_d  = 1'b0;
          if (!supported) begin
            state_d      = StResp;
            resp_code_d  = RespUnsupported;
            resp_rdata_d = '0;
          end else if (misaligned && !SplitEn) begin
            state_d      = StResp;
            resp_code_d  = RespMisaligned;
            resp_rdata_d = '0;
          end else begin
            state_d     = StBeat0;
            mem_req_d   = 1'b1;
            mem_wen_d   = bus.req_wen;
            mem_addr_d  = {bus.req_addr[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};
            mem_wstrb_d = bus.req_wen ? wstrb_lo : '1;
            mem_wdata_d = bus.req_wen ? wdata_lo : '0;
            wdata_hi_d  = wdata_hi;
            wstrb_hi_d  = wstrb_hi;
            split_d     = misaligned;
          end
        end
      end
      StBeat0: begin
        if (bus.mem_ready) begin
          rdata_lo_d = bus.mem_rdata;
          if (bus.mem_err) begin
            state_d      = StResp;
            resp_code_d  = RespBusErr;
            resp_rdata_d = '0;
          end else if (split_q) begin
            state_d     = StBeat1;
            mem_req_d   = 1'b1;
            mem_addr_d  = mem_addr_q + ADDR_WIDTH'(STRB_WIDTH);
            mem_wstrb_d = wen_q ? wstrb_hi_q : '1;
            mem_wdata_d = wen_q ? wdata_hi_q : '0;
          end else begin
            state_d      = StResp;
            resp_code_d  = RespOk;
            resp_rdata_d = wen_q ? '0 : ld_rdata;
          end
        end
      end
      StBeat1: begin
        if (bus.mem_ready) begin
          state_d = StResp;
          if (bus.mem_err) begin
            resp_code_d  = RespBusErr;
            resp_rdata_d = '0;
          end else begin
            resp_code_d  = RespOk;
            resp_rdata_d = wen_q ? '0 : ld_rdata;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '1;
      resp_code_q  <= RespOk;
      resp_rdata_q <= '0;
      funct3_q     <= '0;
      offset_q     <= '0;
      wen_q        <= 1'b0;
      split_q      <= 1'b0;
      wdata_hi_q   <= '0;
      wstrb_hi_q   <= '0;
      rdata_lo_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      resp_code_q  <= resp_code_d;
      resp_rdata_q <= resp_rdata_d;
      funct3_q     <= funct3_d;
      offset_q     <= offset_d;
      wen_q        <= wen_d;
      split_q      <= split_d;
      wdata_hi_q   <= wdata_hi_d;
      wstrb_hi_q   <= wstrb_hi_d;
      rdata_lo_q   <= rdata_lo_d;
    end
  end

  assign bus.req_ready       = (state_q == StIdle);
  assign bus.resp_valid      = (state_q == StResp);
  assign bus.resp_rdata      = resp_rdata_q;
  assign bus.resp_err        = (resp_code_q != RespOk);
  assign bus.resp_misaligned = (resp_code_q == RespMisaligned);
  assign bus.mem_req         = mem_req_q;
  assign bus.mem_wen         = mem_wen_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.mem_wstrb       = mem_wstrb_q;

endmodule

// File: tb/tb_z_core_lsu.sv
// Directed bench for z_core_lsu (32-bit bus) with a small memory responder.
module tb_z_core_lsu;
  import z_core_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 4;

  logic clk = 1'b0;
  logic reset;

  z_core_lsu_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) bus ();

  z_core_lsu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // responder controls (written by the stimulus only)
  int mem_lat    = 0;
  bit err_inject = 1'b0;
  bit resp_block = 1'b0;
  bit late_ready = 1'b0;

  // responder state and request log (written by the responder only)
  int          req_total = 0;
  logic [31:0] log_addr  [64];
  logic [31:0] log_wdata [64];
  logic [3:0]  log_wstrb [64];
  logic        log_wen   [64];
  bit          pend = 1'b0;
  int          cnt  = 0;
  logic [31:0] paddr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: return 32'h8899AABB;
      32'h104: return 32'h11223344;
      default: return 32'h0;
    endcase
  endfunction

  // Memory model: logs every mem_req cycle, answers after mem_lat cycles.
  always @(negedge clk) begin
    bus.mem_ready = 1'b0;
    bus.mem_err   = 1'b0;
    bus.mem_rdata = '0;
    if (late_ready) begin
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hCAFEF00D;
    end
    if (pend) begin
      if (cnt == 0) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem_word(paddr);
        bus.mem_err   = err_inject;
        pend = 1'b0;
      end else begin
        cnt--;
      end
    end
    if (bus.mem_req === 1'b1) begin
      log_addr[req_total % 64]  = bus.mem_addr;
      log_wdata[req_total % 64] = bus.mem_wdata;
      log_wstrb[req_total % 64] = bus.mem_wstrb;
      log_wen[req_total % 64]   = bus.mem_wen;
      req_total++;
      if (!resp_block) begin
        if (mem_lat == 0) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem_word(bus.mem_addr);
          bus.mem_err   = err_inject;
        end else begin
          pend  = 1'b1;
          cnt   = mem_lat - 1;
          paddr = bus.mem_addr;
        end
      end
    end
  end

  // Issue one request at a negedge; return at the negedge resp_valid is seen
  // (lat = cycles from accept) or after 20 cycles.
  task automatic do_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output int nreq);
    int start;
    start          = req_total;
    bus.req_valid  = 1'b1;
    bus.req_wen    = wen;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    nreq = req_total - start;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.mem_req, bus.mem_wen, bus.resp_err,
         bus.resp_misaligned} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 100000", {bus.req_ready, bus.resp_valid,
               bus.mem_req, bus.mem_wen, bus.resp_err, bus.resp_misaligned});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.resp_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h expected zeros", bus.mem_addr, bus.mem_wdata,
               bus.resp_rdata);
    end
    checks++;
    if (bus.mem_wstrb !== 4'hF) begin
      errors++;
      $display("FAIL reset_wstrb: got %b expected 1111", bus.mem_wstrb);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_ready: got %b expected 1", bus.req_ready);
    end
  endtask

  task automatic test_lb();
    int lat, nreq, idx;
    do_req(1'b0, F3Byte, 32'h103, 32'h0, lat, nreq);
    idx = (req_total - 1) % 64;
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL lb_latency: got %0d expected 2", lat);
    end
    checks++;
    if (nreq !== 1 || log_addr[idx] !== 32'h100) begin
      errors++;
      $display("FAIL lb_bus: got %0d reqs addr %h expected 1 req addr 00000100", nreq,
               log_addr[idx]);
    end
    checks++;
    if ({log_wen[idx], log_wstrb[idx]} !== 5'b0_1111) begin
      errors++;
      $display("FAIL lb_wen_strb: got %b expected 01111", {log_wen[idx], log_wstrb[idx]});
    end
    checks++;
    if (bus.resp_rdata !== 32'hFFFFFF88 || bus.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL lb_rdata: got %h err %b expected ffffff88 err 0", bus.resp_rdata,
               bus.resp_err);
    end
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL lb_pulse: got valid %b ready %b expected 0 1", bus.resp_valid,
               bus.req_ready);
    end
  endtask

  task automatic test_lhu();
    int lat, nreq;
    do_req(1'b0, F3HalfU, 32'h102, 32'h0, lat, nreq);
    checks++;
    if (lat !== 2 || nreq !== 1) begin
      errors++;
      $display("FAIL lhu_timing: got lat %0d reqs %0d expected 2 1", lat, nreq);
    end
    checks++;
    if (bus.resp_rdata !== 32'h00008899) begin
      errors++;
      $display("FAIL lhu_rdata: got %h expected 00008899", bus.resp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_sb();
    int lat, nreq, idx;
    do_req(1'b1, F3Byte, 32'h101, 32'hFFFFFF5A, lat, nreq);
    idx = (req_total - 1) % 64;
    checks++;
    if (nreq !== 1 || log_addr[idx] !== 32'h100 || log_wen[idx] !== 1'b1) begin
      errors++;
      $display("FAIL sb_bus: got %0d reqs addr %h wen %b expected 1 00000100 1", nreq,
               log_addr[idx], log_wen[idx]);
    end
    checks++;
    if (log_wstrb[idx] !== 4'b0010) begin
      errors++;
      $display("FAIL sb_wstrb: got %b expected 0010", log_wstrb[idx]);
    end
    checks++;
    if (log_wdata[idx] !== 32'h00005A00) begin
      errors++;
      $display("FAIL sb_wdata: got %h expected 00005a00", log_wdata[idx]);
    end
    checks++;
    if (lat !== 2 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL sb_resp: got lat %0d rdata %h err %b expected 2 0 0", lat,
               bus.resp_rdata, bus.resp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    int lat, nreq, idx;
    do_req(1'b0, F3Word, 32'h102, 32'h0, lat, nreq);
`ifdef Z_CORE_LSU_MISALIGN_SPLIT_EN
    idx = (req_total - 2) % 64;
    checks++;
    if (lat !== 3 || nreq !== 2) begin
      errors++;
      $display("FAIL split_timing: got lat %0d reqs %0d expected 3 2", lat, nreq);
    end
    checks++;
    if (log_addr[idx] !== 32'h100 || log_addr[(idx + 1) % 64] !== 32'h104) begin
      errors++;
      $display("FAIL split_addr: got %h %h expected 00000100 00000104", log_addr[idx],
               log_addr[(idx + 1) % 64]);
    end
    checks++;
    if (bus.resp_rdata !== 32'h33448899 || {bus.resp_err, bus.resp_misaligned} !== 2'b00) begin
      errors++;
      $display("FAIL split_rdata: got %h err %b mis %b expected 33448899 0 0",
               bus.resp_rdata, bus.resp_err, bus.resp_misaligned);
    end
`else
    idx = 0;
    checks++;
    if (lat !== 1 || nreq !== idx) begin
      errors++;
      $display("FAIL misalign_timing: got lat %0d reqs %0d expected 1 0", lat, nreq);
    end
    checks++;
    if ({bus.resp_err, bus.resp_misaligned} !== 2'b11 || bus.resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL misalign_resp: got err %b mis %b rdata %h expected 1 1 0",
               bus.resp_err, bus.resp_misaligned, bus.resp_rdata);
    end
`endif
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse: got %b expected 0", bus.resp_valid);
    end
  endtask

  task automatic test_unsupported();
    int lat, nreq;
    do_req(1'b0, F3Dbl, 32'h100, 32'h0, lat, nreq);
    checks++;
    if (lat !== 1 || nreq !== 0) begin
      errors++;
      $display("FAIL unsup_ld_timing: got lat %0d reqs %0d expected 1 0", lat, nreq);
    end
    checks++;
    if ({bus.resp_err, bus.resp_misaligned} !== 2'b10 || bus.resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL unsup_ld_resp: got err %b mis %b rdata %h expected 1 0 0",
               bus.resp_err, bus.resp_misaligned, bus.resp_rdata);
    end
    @(negedge clk);
    do_req(1'b1, F3ByteU, 32'h100, 32'h12, lat, nreq);
    checks++;
    if (lat !== 1 || nreq !== 0 || {bus.resp_err, bus.resp_misaligned} !== 2'b10) begin
      errors++;
      $display("FAIL unsup_st: got lat %0d reqs %0d err %b mis %b expected 1 0 1 0", lat,
               nreq, bus.resp_err, bus.resp_misaligned);
    end
    @(negedge clk);
  endtask

  task automatic test_wait_hold();
    int lat, nreq;
    mem_lat = 2;
    do_req(1'b0, F3Word, 32'h104, 32'h0, lat, nreq);
    mem_lat = 0;
    checks++;
    if (lat !== 4 || nreq !== 1) begin
      errors++;
      $display("FAIL wait_timing: got lat %0d reqs %0d expected 4 1", lat, nreq);
    end
    checks++;
    if (bus.resp_rdata !== 32'h11223344) begin
      errors++;
      $display("FAIL wait_rdata: got %h expected 11223344", bus.resp_rdata);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h11223344 || bus.resp_err !== 1'b0)
    begin
      errors++;
      $display("FAIL hold_rdata: got valid %b rdata %h err %b expected 0 11223344 0",
               bus.resp_valid, bus.resp_rdata, bus.resp_err);
    end
  endtask

  task automatic test_bus_err();
    int lat, nreq;
    err_inject = 1'b1;
    do_req(1'b0, F3Word, 32'h100, 32'h0, lat, nreq);
    err_inject = 1'b0;
    checks++;
    if (lat !== 2 || {bus.resp_err, bus.resp_misaligned} !== 2'b10 ||
        bus.resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL buserr_resp: got lat %0d err %b mis %b rdata %h expected 2 1 0 0", lat,
               bus.resp_err, bus.resp_misaligned, bus.resp_rdata);
    end
    @(negedge clk);
    checks++;
    if (bus.resp_err !== 1'b1) begin
      errors++;
      $display("FAIL buserr_hold: got %b expected 1", bus.resp_err);
    end
    // back-to-back good access after the error
    do_req(1'b0, F3Word, 32'h100, 32'h0, lat, nreq);
    checks++;
    if (lat !== 2 || bus.resp_rdata !== 32'h8899AABB || bus.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL after_err_lw: got lat %0d rdata %h err %b expected 2 8899aabb 0", lat,
               bus.resp_rdata, bus.resp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    resp_block     = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_wen    = 1'b0;
    bus.req_funct3 = F3Word;
    bus.req_addr   = 32'h100;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_beat0: got mem_req %b ready %b expected 1 0", bus.mem_req,
               bus.req_ready);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready, bus.mem_req, bus.resp_valid} !== 3'b100 ||
        bus.mem_addr !== 32'h0 || bus.mem_wstrb !== 4'hF) begin
      errors++;
      $display("FAIL mid_async_reset: got %b addr %h strb %b expected 100 0 1111",
               {bus.req_ready, bus.mem_req, bus.resp_valid}, bus.mem_addr, bus.mem_wstrb);
    end
    @(negedge clk);
    reset = 1'b0;
    #1 late_ready = 1'b1;
    @(negedge clk);
    #1 late_ready = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) seen++;
    end
    resp_block = 1'b0;
    checks++;
    if (seen !== 0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL late_ready: got %0d resp_valid cycles ready %b expected 0 1", seen,
               bus.req_ready);
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    reset          = 1'b1;
    test_reset();
    test_lb();
    test_lhu();
    test_sb();
    test_misaligned();
    test_unsupported();
    test_wait_hold();
    test_bus_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/z_core_lsu.md
Z_CORE_LSU -- requirements
Module: z_core_lsu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, on ports clk and reset.
REQ-002 Parameters SHALL be: DATA_WIDTH, default 32, bus width 32 or 64; ADDR_WIDTH, default 32, address width; STRB_WIDTH, default DATA_WIDTH/8, byte lanes.
REQ-003 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  async active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V size/sign code
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, LSB-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  extended load data
- resp_err  out  1  request failed
- resp_misaligned  out  1  failure cause is misalignment
- mem_req  out  1  one-cycle bus request pulse
- mem_wen  out  1  bus write
- mem_addr  out  ADDR_WIDTH  STRB_WIDTH-aligned address
- mem_wdata  out  DATA_WIDTH  lane-positioned write data
- mem_wstrb  out  STRB_WIDTH  byte strobes
- mem_rdata  in  DATA_WIDTH  read data
- mem_ready  in  1  bus transaction done
- mem_err  in  1  bus error, qualified by mem_ready

Function
REQ-004 The state machine SHALL have the states IDLE, BEAT0, BEAT1 and RESP.
REQ-005 req_ready SHALL be 1 only in IDLE; a request is accepted on the cycle where req_valid and req_ready are both 1.
REQ-006 Supported funct3 codes SHALL be: loads 000/001/010/100/101; stores 000/001/010; when DATA_WIDTH=64, also load 011 and 110, and store 011.
REQ-007 An unsupported funct3 SHALL go IDLE->RESP with resp_err=1, resp_misaligned=0, and no mem_req.
REQ-008 On accept, the block SHALL enter BEAT0 and assert mem_req for exactly the next cycle; mem_addr SHALL equal req_addr with its low log2(STRB_WIDTH) bits cleared.
REQ-009 For a store, mem_wdata SHALL be req_wdata shifted left by 8*offset bits, with unused lanes 0, and mem_wstrb SHALL be ((1<<size)-1)<<offset.
REQ-010 For a load, mem_wstrb SHALL be all ones and mem_wen SHALL be 0.
REQ-011 mem_ready SHALL be ignored except in BEAT0/BEAT1.
REQ-012 When mem_ready=1 arrives, the block SHALL capture data and go to RESP.
REQ-013 In RESP, resp_valid SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
- Minimum latency, accept to resp_valid, is 2 cycles plus memory wait.
REQ-014 Load data SHALL be taken from byte offset onward: sign-extended for funct3[2]=0 and zero-extended for funct3[2]=1.
REQ-015 resp_rdata SHALL be 0 for stores and for any errored response.
REQ-016 mem_err=1 with mem_ready SHALL give resp_err=1 and resp_misaligned=0.
REQ-017 resp_rdata, resp_err and resp_misaligned SHALL hold their values until the next resp_valid.
REQ-018 An access is misaligned when offset+size exceeds STRB_WIDTH.

Reset
REQ-019 Reset SHALL immediately force: state IDLE; req_ready=1; resp_valid=0; mem_req=0; mem_wen=0; mem_addr, mem_wdata and resp_rdata to 0; mem_wstrb to all ones; resp_err=0; resp_misaligned=0.
REQ-020 Reset asserted mid-transaction SHALL abandon that transaction; a late mem_ready SHALL then be ignored per REQ-011.

Configuration
REQ-021 When the macro Z_CORE_LSU_MISALIGN_SPLIT_EN is undefined, a misaligned access SHALL go IDLE->RESP with resp_err=1, resp_misaligned=1, and no mem_req.
REQ-022 When Z_CORE_LSU_MISALIGN_SPLIT_EN is defined, a misaligned access SHALL run BEAT0 at the aligned address, then BEAT1 at aligned+STRB_WIDTH, with a fresh mem_req pulse on the cycle after BEAT0's mem_ready.
- The BEAT1 address wraps modulo 2^ADDR_WIDTH.
- Each beat's strobes and data cover only its own bytes.
- Load bytes from both beats are merged before extension.
REQ-023 With the split enabled, mem_err in BEAT0 SHALL skip BEAT1 and go to RESP.

Structure
REQ-024 The shared package z_core_pkg SHALL hold the funct3 size codes, the state encodings and the LSU response codes.
REQ-025 Lane shift, strobe generation and sign/zero extension SHALL be a combinational sub-module, z_core_lsu_align.

Verification
REQ-026 The bench SHALL cover these scenarios (DATA_WIDTH=32, word 0x100=0x8899AABB, word 0x104=0x11223344):
- LB at 0x103 -> one mem_req at addr 0x100; resp_rdata=0xFFFFFF88.
- LHU at 0x102 -> resp_rdata=0x00008899.
- SB at 0x101 with data 0x5A -> mem_wstrb=0010, mem_wdata=0x00005A00, mem_wen=1.
- LW at 0x102, macro undefined -> resp_valid 1 cycle after accept, resp_err=1, resp_misaligned=1, no mem_req.
- LW at 0x102, macro defined -> mem_req at 0x100 then at 0x104; resp_rdata=0x33448899.
- LW at 0x100 with mem_err=1 -> resp_err=1, resp_rdata=0; reset in BEAT0 then a late mem_ready -> no resp_valid, req_ready=1.
